// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// HI/LO register pair with a multi-cycle radix-2 restoring divider.
// The pair is written either directly from the ALU (mult/multu/mthi/mtlo) or
// by the divider when a div/divu completes. A division takes one start cycle,
// 32 CALC cycles and one DONE cycle; the pipeline is held for the first 33.
//
// Ports
//   clk        in   1   clock, all state changes on the rising edge
//   rst        in   1   synchronous active-high reset
//   we         in   1   direct HI/LO write request
//   wdata      in  64   direct write value, [63:32]=HI, [31:0]=LO
//   div_start  in   1   start a division (a/b/div_signed sampled this cycle)
//   div_signed in   1   1=div (two's complement), 0=divu
//   a          in  32   dividend
//   b          in  32   divisor
//   flush      in   1   pipeline cancel: aborts division, suppresses writes
//   hilo       out 64   registered HI/LO, [63:32]=HI (remainder after div)
//   div_busy   out  1   high in CALC and DONE
//   div_done   out  1   high for the single DONE cycle
//   stall      out  1   pipeline hold request
// -----------------------------------------------------------------------------
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [63:0] wdata,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [63:0] hilo,
    output logic        div_busy,
    output logic        div_done,
    output logic        stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [31:0] rem_q,     rem_d;
    logic [31:0] quot_q,    quot_d;
    logic [31:0] divisor_q, divisor_d;
    logic        q_neg_q,   q_neg_d;
    logic        r_neg_q,   r_neg_d;
    logic [63:0] hilo_q,    hilo_d;

    // Operand magnitudes; divu passes the raw bit patterns through.
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    assign a_mag = (div_signed && a[31]) ? (~a + 32'd1) : a;
    assign b_mag = (div_signed && b[31]) ? (~b + 32'd1) : b;

    // One restoring step. The partial remainder is kept below the divisor,
    // so after the shift it fits in 33 bits; bit 32 of the difference is the
    // borrow and tells whether the subtraction is kept.
    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic        take;
    assign rem_shift = {rem_q, quot_q[31]};
    assign rem_sub   = rem_shift - {1'b0, divisor_q};
    assign take      = ~rem_sub[32];

    // Sign correction applied in DONE.
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    assign quot_fix = q_neg_q ? (~quot_q + 32'd1) : quot_q;
    assign rem_fix  = r_neg_q ? (~rem_q  + 32'd1) : rem_q;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        hilo_d    = hilo_q;
        stall     = 1'b0;
        div_done  = 1'b0;

        if (flush) begin
            // Cancel wins over everything except reset: no write, no stall.
            state_d = S_IDLE;
            cnt_d   = 5'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (div_start) begin
                        // div_start outranks a simultaneous direct write.
                        stall     = 1'b1;
                        state_d   = S_CALC;
                        cnt_d     = 5'd0;
                        rem_d     = 32'd0;
                        quot_d    = a_mag;
                        divisor_d = b_mag;
                        // Divide by zero yields {a, all-ones}: the raw
                        // quotient is already all-ones, so its negation is
                        // suppressed; negating |a| restores a for HI.
                        q_neg_d   = div_signed & (a[31] ^ b[31]) & (b != 32'd0);
                        r_neg_d   = div_signed & a[31];
                    end else if (we) begin
                        hilo_d = wdata;
                    end
                end
                S_CALC: begin
                    stall  = 1'b1;
                    rem_d  = take ? rem_sub[31:0] : rem_shift[31:0];
                    quot_d = {quot_q[30:0], take};
                    cnt_d  = cnt_q + 5'd1;   // wraps to 0 on the last step
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    div_done = 1'b1;
                    hilo_d   = {rem_fix, quot_fix};
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (rst) begin
            stall    = 1'b0;
            div_done = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            divisor_q <= 32'd0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            hilo_q    <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            hilo_q    <= hilo_d;
        end
    end

    assign hilo     = hilo_q;
    assign div_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//
// Self-checking bench for hilo_unit. A cycle-countdown model derives the
// expected hilo/div_busy/div_done/stall from plain arithmetic and is compared
// against the DUT on every falling edge; directed tests add hand-computed
// literal expectations for results, stall length and done pulses.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [63:0] wdata;
    logic        div_start;
    logic        div_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [63:0] hilo;
    logic        div_busy;
    logic        div_done;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    hilo_unit dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wdata      (wdata),
        .div_start  (div_start),
        .div_signed (div_signed),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .hilo       (hilo),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: result from integer arithmetic, timing as a count
    // of cycles still owed by the divider (33 after acceptance).
    // ------------------------------------------------------------------
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        int sx, sy, q, r;
        if (y == 32'd0)
            return {x, 32'hFFFF_FFFF};
        if (!s)
            return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return {32'h0000_0000, 32'h8000_0000};
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    int          m_left = 0;
    logic [63:0] m_hilo = 64'd0;
    logic [63:0] m_pend = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_hilo = 64'd0;
            m_left = 0;
        end else if (flush) begin
            m_left = 0;
        end else if (m_left == 0) begin
            if (div_start) begin
                m_left = 33;
                m_pend = ref_div(a, b, div_signed);
            end else if (we) begin
                m_hilo = wdata;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0)
                m_hilo = m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_hilo",     hilo,     m_hilo);
            check("model_div_busy", {63'd0, div_busy}, {63'd0, m_left > 0});
            check("model_div_done", {63'd0, div_done},
                  {63'd0, (m_left == 1) && !flush && !rst});
            check("model_stall",    {63'd0, stall},
                  {63'd0, !rst && !flush && ((m_left == 0 && div_start) || m_left > 1)});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; all drive at 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and observe a fixed 36-cycle window, counting
    // stall and div_done cycles. flush_at (-1 = never) pulses flush in
    // that window cycle.
    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                           input int flush_at, output int stalls, output int dones);
        stalls     = 0;
        dones      = 0;
        div_start  = 1'b1;
        a          = x;
        b          = y;
        div_signed = s;
        for (int i = 0; i < 36; i++) begin
            flush = (i == flush_at);
            @(negedge clk);
            if (stall)    stalls++;
            if (div_done) dones++;
            tick();
            div_start = 1'b0;
            we        = 1'b0;
            flush     = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [10] = '{
        '{32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, "divu_100_7"},
        '{32'hFFFFFFF9,  32'd2,         1'b1, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2"},
        '{32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000, "div_min_m1"},
        '{32'd5,         32'd0,         1'b0, 64'h00000005_FFFFFFFF, "divu_by_zero"},
        '{32'hFFFFFFF9,  32'd0,         1'b1, 64'hFFFFFFF9_FFFFFFFF, "div_by_zero"},
        '{32'hFFFFFF9C,  32'd7,         1'b1, 64'hFFFFFFFE_FFFFFFF2, "div_m100_7"},
        '{32'd100,       32'hFFFFFFF9,  1'b1, 64'h00000002_FFFFFFF2, "div_100_m7"},
        '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 64'hFFFFFFFE_0000000E, "div_m100_m7"},
        '{32'hFFFFFFFF,  32'd1,         1'b0, 64'h00000000_FFFFFFFF, "divu_max_1"},
        '{32'h80000000,  32'hFFFFFFFF,  1'b0, 64'h80000000_00000000, "divu_big"}
    };

    initial begin
        int stalls, dones;
        logic [63:0] prior;

        rst = 1'b1; we = 1'b0; wdata = 64'd0; div_start = 1'b0;
        div_signed = 1'b0; a = 32'd0; b = 32'd0; flush = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_hilo",  hilo, 64'd0);
        check("reset_busy",  {63'd0, div_busy}, 64'd0);
        check("reset_stall", {63'd0, stall},    64'd0);

        // Result table; each division stalls 33 cycles and pulses done once.
        foreach (vecs[i]) begin
            run_div(vecs[i].x, vecs[i].y, vecs[i].s, -1, stalls, dones);
            check({vecs[i].name, "_hilo"}, hilo, vecs[i].exp);
            check({vecs[i].name, "_stalls"}, 64'(stalls), 64'd33);
            check({vecs[i].name, "_dones"},  64'(dones),  64'd1);
        end

        // Direct write, then a flushed write that must not land.
        we = 1'b1; wdata = 64'h12345678_9ABCDEF0;
        tick();
        we = 1'b0;
        check("we_write", hilo, 64'h12345678_9ABCDEF0);
        we = 1'b1; flush = 1'b1; wdata = 64'hCAFEF00D_01234567;
        tick();
        we = 1'b0; flush = 1'b0;
        check("we_flushed", hilo, 64'h12345678_9ABCDEF0);

        // we and div_start together: the division wins.
        we = 1'b1; wdata = 64'hDEADBEEF_DEADBEEF;
        run_div(32'd9, 32'd4, 1'b0, -1, stalls, dones);
        check("we_vs_start_hilo", hilo, 64'h00000001_00000002);

        // Flush during DONE: no write, no done pulse.
        prior = hilo;
        run_div(32'd100, 32'd7, 1'b0, 33, stalls, dones);
        check("flush_done_hilo",  hilo, prior);
        check("flush_done_dones", 64'(dones), 64'd0);

        // Flush on the 10th CALC cycle, then restart immediately.
        div_start = 1'b1; a = 32'd100; b = 32'd7; div_signed = 1'b0;
        tick();
        div_start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_calc_busy", {63'd0, div_busy}, 64'd0);
        check("flush_calc_hilo", hilo, prior);
        run_div(32'hFFFFFF9C, 32'd7, 1'b1, -1, stalls, dones);
        check("restart_hilo",   hilo, 64'hFFFFFFFE_FFFFFFF2);
        check("restart_stalls", 64'(stalls), 64'd33);
        check("restart_dones",  64'(dones),  64'd1);

        // div_start during CALC is ignored.
        div_start = 1'b1; a = 32'd100; b = 32'd7; div_signed = 1'b0;
        tick();
        div_start = 1'b0;
        repeat (4) tick();
        div_start = 1'b1; a = 32'd1000; b = 32'd3; div_signed = 1'b1;
        tick();
        div_start = 1'b0;
        repeat (32) tick();
        check("ignored_start_hilo", hilo, 64'h00000002_0000000E);

        // Reset mid-CALC with every other input active.
        div_start = 1'b1; a = 32'd100; b = 32'd7; div_signed = 1'b0;
        tick();
        div_start = 1'b0;
        repeat (5) tick();
        rst = 1'b1; we = 1'b1; div_start = 1'b1; flush = 1'b1; wdata = 64'h1;
        tick();
        rst = 1'b0; we = 1'b0; div_start = 1'b0; flush = 1'b0;
        check("rst_mid_hilo", hilo, 64'd0);
        check("rst_mid_busy", {63'd0, div_busy}, 64'd0);
        check("rst_mid_done", {63'd0, div_done}, 64'd0);
        check("rst_mid_stall", {63'd0, stall},   64'd0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
